// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronised line, fixed 11-bit frame (start, 8 data, parity slot, stop),
// single-word holding register with valid/ready handshake and sticky overrun flag.
module uart_receiver (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_data,
   input  logic [1:0]  cfg_parity_setting,
   input  logic [31:0] cfg_clkSpeed_over_bdRate,
   input  logic        rx_ready,
   output logic [7:0]  rx_data_word,
   output logic        rx_valid,
   output logic        rx_parity_err,
   output logic        rx_frame_err,
   output logic        rx_overrun,
   output logic        rx_busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Slot modes 01/10 check odd/even parity over data plus slot; 00/11 never flag.
   function automatic logic parity_err_f(input logic [1:0] mode, input logic [7:0] data,
                                         input logic slot);
      logic p;
      p = (^data) ^ slot;
      case (mode)
         2'b01:   parity_err_f = ~p;
         2'b10:   parity_err_f = p;
         default: parity_err_f = 1'b0;
      endcase
   endfunction

   state_t      state_r, state_nxt_s;
   logic        sync1_r, s_rx_r, rx_prev_r;
   logic [31:0] timer_r, timer_nxt_s;
   logic [2:0]  idx_r, idx_nxt_s;
   logic [7:0]  shift_r, shift_nxt_s;
   logic [31:0] d_r, d_nxt_s;
   logic        perr_r, perr_nxt_s;
   logic        busy_r;
   logic        complete_s, ferr_s, accept_s;
   logic [7:0]  word_r;
   logic        valid_r, perr_out_r, ferr_out_r, overrun_r;

   assign rx_data_word  = word_r;
   assign rx_valid      = valid_r;
   assign rx_parity_err = perr_out_r;
   assign rx_frame_err  = ferr_out_r;
   assign rx_overrun    = overrun_r;
   assign rx_busy       = busy_r;
   assign accept_s      = valid_r & rx_ready;

   // Next-state and bit-timer datapath for the frame FSM.
   always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r + 32'd1;
      idx_nxt_s   = idx_r;
      shift_nxt_s = shift_r;
      d_nxt_s     = d_r;
      perr_nxt_s  = perr_r;
      complete_s  = 1'b0;
      ferr_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            timer_nxt_s = 32'd0;
            if (rx_prev_r && !s_rx_r) begin
               state_nxt_s = ST_START;
               d_nxt_s     = (cfg_clkSpeed_over_bdRate < 32'd2) ? 32'd2 : cfg_clkSpeed_over_bdRate;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (timer_r == ((d_r >> 1) - 32'd1)) begin
               timer_nxt_s = 32'd0;
               idx_nxt_s   = 3'd0;
               state_nxt_s = s_rx_r ? ST_IDLE : ST_DATA;
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_DATA: begin
            if (timer_r == (d_r - 32'd1)) begin
               shift_nxt_s[idx_r] = s_rx_r;
               timer_nxt_s        = 32'd0;
               idx_nxt_s          = idx_r + 3'd1;
               state_nxt_s        = (idx_r == 3'd7) ? ST_PARITY : ST_DATA;
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (timer_r == (d_r - 32'd1)) begin
               perr_nxt_s  = parity_err_f(cfg_parity_setting, shift_r, s_rx_r);
               timer_nxt_s = 32'd0;
               state_nxt_s = ST_STOP;
            end else begin
               state_nxt_s = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (timer_r == (d_r - 32'd1)) begin
               complete_s  = 1'b1;
               ferr_s      = ~s_rx_r;
               timer_nxt_s = 32'd0;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         default: begin
            timer_nxt_s = 32'd0;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Synchroniser, FSM state and frame datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_r   <= 1'b1;
         s_rx_r    <= 1'b1;
         rx_prev_r <= 1'b1;
         state_r   <= ST_IDLE;
         timer_r   <= 32'd0;
         idx_r     <= 3'd0;
         shift_r   <= 8'h00;
         d_r       <= 32'd2;
         perr_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         sync1_r   <= rx_data;
         s_rx_r    <= sync1_r;
         rx_prev_r <= s_rx_r;
         state_r   <= state_nxt_s;
         timer_r   <= timer_nxt_s;
         idx_r     <= idx_nxt_s;
         shift_r   <= shift_nxt_s;
         d_r       <= d_nxt_s;
         perr_r    <= perr_nxt_s;
         busy_r    <= (state_nxt_s != ST_IDLE);
      end
   end

   // Holding register: a completed frame loads only if the slot is empty or being freed now.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_r     <= 8'h00;
         valid_r    <= 1'b0;
         perr_out_r <= 1'b0;
         ferr_out_r <= 1'b0;
         overrun_r  <= 1'b0;
      end else begin
         if (complete_s && (!valid_r || accept_s)) begin
            word_r     <= shift_r;
            perr_out_r <= perr_r;
            ferr_out_r <= ferr_s;
            valid_r    <= 1'b1;
         end else if (accept_s) begin
            valid_r <= 1'b0;
         end
         if (complete_s && valid_r && !accept_s) begin
            overrun_r <= 1'b1;
         end else if (accept_s) begin
            overrun_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed cases plus randomised frames checked
// against a frame-level reference queue.
module tb_uart_receiver;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_data;
   logic [1:0]  cfg_parity_setting;
   logic [31:0] cfg_clkSpeed_over_bdRate;
   logic        rx_ready;
   logic [7:0]  rx_data_word;
   logic        rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy;

   int total = 0;
   int bad   = 0;
   logic [9:0] exp_q[$];
   logic [9:0] got_q[$];
   int got_rd = 0;
   int exp_rd = 0;
   int valid_cycles = 0;

   uart_receiver dut (
      .clk                     (clk),
      .rst                     (rst),
      .rx_data                 (rx_data),
      .cfg_parity_setting      (cfg_parity_setting),
      .cfg_clkSpeed_over_bdRate(cfg_clkSpeed_over_bdRate),
      .rx_ready                (rx_ready),
      .rx_data_word            (rx_data_word),
      .rx_valid                (rx_valid),
      .rx_parity_err           (rx_parity_err),
      .rx_frame_err            (rx_frame_err),
      .rx_overrun              (rx_overrun),
      .rx_busy                 (rx_busy)
   );

   always #5 clk = ~clk;

   // Record every accepted word as {parity_err, frame_err, data}.
   always @(negedge clk) begin
      if (rst && rx_valid) begin
         valid_cycles = valid_cycles + 1;
         if (rx_ready) got_q.push_back({rx_parity_err, rx_frame_err, rx_data_word});
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_perr(input logic [1:0] mode, input logic [7:0] b,
                                       input logic slot);
      int ones;
      ones = $countones(b) + int'(slot);
      if (mode == 2'b01) return (ones % 2) == 0;
      if (mode == 2'b10) return (ones % 2) == 1;
      return 1'b0;
   endfunction

   task automatic expect_frame(input logic [1:0] mode, input logic [7:0] b, input logic slot,
                               input logic stop);
      exp_q.push_back({model_perr(mode, b, slot), ~stop, b});
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one full frame at per clocks per bit; optionally scramble cfg once the frame is underway.
   task automatic send_frame(input logic [7:0] b, input logic slot, input logic stop,
                             input int per, input bit scramble);
      rx_data = 1'b0;
      tick(per);
      for (int i = 0; i < 8; i++) begin
         if (scramble && i == 1) cfg_clkSpeed_over_bdRate = $urandom();
         rx_data = b[i];
         tick(per);
      end
      rx_data = slot;
      tick(per);
      rx_data = stop;
      tick(per);
      rx_data = 1'b1;
   endtask

   task automatic check_rx(input string tag);
      int n_got, n_exp;
      n_got = got_q.size() - got_rd;
      n_exp = exp_q.size() - exp_rd;
      check({tag, "_count"}, n_got, n_exp);
      for (int i = 0; i < n_exp && i < n_got; i++)
         check({tag, "_frame"}, {22'd0, got_q[got_rd + i]}, {22'd0, exp_q[exp_rd + i]});
      got_rd = got_q.size();
      exp_rd = exp_q.size();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_word"}, {24'd0, rx_data_word}, 32'd0);
      check({tag, "_flags"}, {27'd0, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy},
            32'd0);
   endtask

   initial begin
      int vc0, per, gap;
      logic [7:0] b;
      logic [1:0] mode;
      logic slot, stop;

      rst = 1'b0;
      rx_data = 1'b1;
      rx_ready = 1'b1;
      cfg_parity_setting = 2'b10;
      cfg_clkSpeed_over_bdRate = 32'd16;
      tick(3);
      check_all_zero("reset_init");
      rst = 1'b1;
      tick(5);

      // Even parity, clean frame; valid must pulse exactly one cycle.
      vc0 = valid_cycles;
      send_frame(8'hA5, 1'b0, 1'b1, 16, 1'b0);
      expect_frame(2'b10, 8'hA5, 1'b0, 1'b1);
      tick(32);
      check_rx("even_a5");
      check("even_a5_pulse", valid_cycles - vc0, 32'd1);

      // Odd parity good/bad slot.
      cfg_parity_setting = 2'b01;
      send_frame(8'h01, 1'b1, 1'b1, 16, 1'b0);
      expect_frame(2'b01, 8'h01, 1'b1, 1'b1);
      tick(32);
      send_frame(8'h01, 1'b0, 1'b1, 16, 1'b0);
      expect_frame(2'b01, 8'h01, 1'b0, 1'b1);
      tick(32);
      check_rx("odd_01");

      // Short low glitch is a false start.
      vc0 = valid_cycles;
      rx_data = 1'b0;
      tick(5);
      rx_data = 1'b1;
      tick(10);
      check("glitch_busy", {31'd0, rx_busy}, 32'd0);
      tick(40);
      check("glitch_novalid", valid_cycles - vc0, 32'd0);
      check_rx("glitch");

      // Overrun: two back-to-back frames with consumer stalled.
      cfg_parity_setting = 2'b00;
      cfg_clkSpeed_over_bdRate = 32'd8;
      rx_ready = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b1, 8, 1'b0);
      send_frame(8'h7E, 1'b1, 1'b1, 8, 1'b0);
      tick(24);
      check("ovr_valid", {31'd0, rx_valid}, 32'd1);
      check("ovr_word", {24'd0, rx_data_word}, 32'h3C);
      check("ovr_flag", {31'd0, rx_overrun}, 32'd1);
      expect_frame(2'b00, 8'h3C, 1'b0, 1'b1);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      check("ovr_clr_valid", {31'd0, rx_valid}, 32'd0);
      check("ovr_clr_flag", {31'd0, rx_overrun}, 32'd0);
      rx_ready = 1'b1;
      tick(4);
      check_rx("ovr");

      // Bad stop bit followed by a 40-bit break: one frame only.
      cfg_clkSpeed_over_bdRate = 32'd16;
      send_frame(8'h96, 1'b1, 1'b0, 16, 1'b0);
      rx_data = 1'b0;
      tick(40 * 16);
      rx_data = 1'b1;
      expect_frame(2'b00, 8'h96, 1'b1, 1'b0);
      tick(48);
      check_rx("break");

      // Reset in the middle of data bit 4 abandons the frame.
      rx_data = 1'b0;
      tick(16);
      for (int i = 0; i < 4; i++) begin
         rx_data = i[0];
         tick(16);
      end
      rx_data = 1'b1;
      tick(8);
      rst = 1'b0;
      tick(1);
      check_all_zero("reset_mid");
      tick(3);
      rst = 1'b1;
      tick(5);
      send_frame(8'h5A, 1'b0, 1'b1, 16, 1'b0);
      expect_frame(2'b00, 8'h5A, 1'b0, 1'b1);
      tick(32);
      check_rx("after_reset");

      // D of 0 and 1 behave as D=2.
      cfg_clkSpeed_over_bdRate = 32'd0;
      send_frame(8'h81, 1'b0, 1'b1, 2, 1'b0);
      expect_frame(2'b00, 8'h81, 1'b0, 1'b1);
      tick(8);
      cfg_clkSpeed_over_bdRate = 32'd1;
      send_frame(8'h81, 1'b0, 1'b1, 2, 1'b0);
      expect_frame(2'b00, 8'h81, 1'b0, 1'b1);
      tick(8);
      check_rx("d_min");

      // Randomised frames, mid-frame cfg scrambling, occasional back-to-back.
      for (int k = 0; k < 10; k++) begin
         b    = 8'($urandom());
         mode = 2'($urandom_range(0, 3));
         slot = 1'($urandom_range(0, 1));
         stop = ($urandom_range(0, 3) != 0);
         per  = $urandom_range(2, 12);
         gap  = stop ? $urandom_range(0, 1) : 1;
         cfg_parity_setting = mode;
         cfg_clkSpeed_over_bdRate = 32'(per);
         send_frame(b, slot, stop, per, 1'b1);
         expect_frame(mode, b, slot, stop);
         tick(gap * per);
      end
      tick(40);
      check_rx("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have port clk  in  1  system clock; all flops rising-edge.
REQ-002 SHALL have port rst  in  1  asynchronous reset, active-low; clears all state while 0.
REQ-003 SHALL have port rx_data  in  1  asynchronous serial line; idles high.
REQ-004 SHALL have port cfg_parity_setting  in  2  parity-slot checking mode:
- 00 none
- 01 odd
- 10 even
- 11 none
REQ-005 SHALL have port cfg_clkSpeed_over_bdRate  in  32  clk cycles per bit (D).
REQ-006 SHALL have port rx_ready  in  1  consumer accepts the held word when high.
REQ-007 SHALL have port rx_data_word  out  8  received byte, LSB = first data bit.
REQ-008 SHALL have port rx_valid  out  1  rx_data_word and error flags are valid.
REQ-009 SHALL have port rx_parity_err  out  1  parity mismatch on the held word.
REQ-010 SHALL have port rx_frame_err  out  1  stop bit sampled 0 on the held word.
REQ-011 SHALL have port rx_overrun  out  1  sticky; a frame was dropped because rx_valid was still high.
REQ-012 SHALL have port rx_busy  out  1  high in every state except IDLE.

Function
REQ-013 SHALL synchronise rx_data through a 2-flop synchroniser reset to 1; all decisions use the synchronised value (s_rx).
REQ-014 SHALL receive a fixed 11-bit frame, matching the transmitter: start(0), d0..d7, parity slot, stop(1).
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL latch D on leaving IDLE; the effective D is max(D, 2).
REQ-017 SHALL hold D constant for the whole frame, even if cfg changes mid-frame.
REQ-018 IDLE: a falling edge on s_rx (previous 1, current 0) SHALL clear the 32-bit bit timer and enter START.
REQ-019 START: at timer == (D>>1)-1, SHALL sample s_rx.
- 1: false start; return to IDLE with no output.
- 0: clear timer; enter DATA with bit index 0.
REQ-020 DATA: each time timer == D-1, SHALL sample s_rx into data bit [index], clear the timer, and increment the index.
- After index 7 is sampled, enter PARITY.
REQ-021 PARITY: at timer == D-1, SHALL sample the parity slot and compute the error.
- 01 (odd): error if XOR(data, slot) == 0.
- 10 (even): error if XOR(data, slot) == 1.
- 00/11: error = 0; slot value ignored.
- Then enter STOP.
REQ-022 STOP: at timer == D-1, SHALL sample the stop bit (frame error if 0) and complete the frame; then enter IDLE in the same cycle.
REQ-023 Back-to-back frames SHALL be received with zero idle bits between them.
REQ-024 On frame completion with rx_valid == 0, SHALL load rx_data_word, rx_parity_err and rx_frame_err, and assert rx_valid in the next cycle.
- Latency from stop-bit sample edge to rx_valid = 1 clk.
REQ-025 SHALL hold rx_valid, the word and both error flags stable until a cycle with rx_valid & rx_ready; rx_valid then deasserts in the next cycle.
REQ-026 On frame completion with rx_valid == 1 and no acceptance in that same cycle, SHALL discard the new frame, keep the held word, and set rx_overrun.
REQ-027 If acceptance and completion coincide, SHALL load the new frame and keep rx_valid high; no overrun.
REQ-028 rx_overrun SHALL clear only on a cycle where rx_valid & rx_ready.
- If overrun is set again in that same cycle, the set wins.
REQ-029 A break (line held 0) SHALL yield one frame with rx_frame_err = 1.
- No further frame starts until s_rx returns to 1 and falls again.
REQ-030 The bit timer SHALL be 32-bit unsigned and SHALL be cleared at every sample point; it never wraps within a frame.

Reset
REQ-031 While rst == 0, SHALL force:
- state IDLE; synchroniser = 1; timer and bit index = 0
- rx_data_word = 0x00; rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy = 0
REQ-032 Reset asserted mid-frame SHALL abandon the frame without producing rx_valid.
REQ-033 After reset release, a new frame SHALL require a fresh falling edge.

Verification
REQ-034 D=16, parity 10, rx_ready=1; send 0xA5 with slot 0, stop 1 -> rx_valid pulses 1 cycle, word 0xA5, both error flags 0.
REQ-035 D=16, parity 01; send 0x01 with slot 1 -> rx_parity_err = 1, word 0x01.
- Resend with slot 0 -> rx_parity_err = 0.
REQ-036 D=16; low glitch of 5 cycles on rx_data -> returns to IDLE, no rx_valid, rx_busy low again within 10 cycles.
REQ-037 D=8, rx_ready=0; send 0x3C then 0x7E back-to-back -> word stays 0x3C, rx_overrun = 1.
- Then pulse rx_ready -> rx_valid = 0, rx_overrun = 0.
REQ-038 D=16; stop bit 0 -> rx_frame_err = 1.
- Hold line low 40 bits -> exactly one frame reported.
REQ-039 D=16; assert rst at data bit 4, release, send 0x5A -> only 0x5A is delivered.
- All outputs read 0 during reset.
REQ-040 D=0 and D=1 -> behaves as D=2; 0x81 received correctly.
